mem_port_ctrl: RTL and testbench

Memory-side stage directly downstream of the Phaethon core's RAM port. It accepts the core's level-sensitive `readReq`/`writeReq` with registered `ramAddress`/`ramOut`, and services them against an internal word RAM with the fixed timing the core's wait-state sequence expects. Before the core runs, the block owns memory through three phases: clear, program load over a valid/ready port, then release via `cpuRun`. It also decodes one memory-mapped output register and counts out-of-range accesses.

---
 rtl/mem_port_ctrl_pkg.sv | 25 ++
 rtl/mem_port_ctrl_if.sv | 34 +++
 rtl/mem_port_ctrl_ram.sv | 49 ++++
 rtl/mem_port_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_mem_port_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_ctrl_pkg.sv
// Shared types and constants for the Phaethon memory-side stage.
// Holds the phase enum, the default MMIO address and the error-count helper.
package phaethon_mem_pkg;

    localparam int          WORD_W        = 32;
    localparam logic [31:0] MMIO_ADDR_DEF = 32'hFFFF_FF00;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2
    } mem_state_t;

    // Saturating increment so a runaway bad-address loop pins at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = 8'hFF;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_port_ctrl_if.sv
// Bus bundle between the core/loader side (master) and the memory stage (slave).
// Carries the core RAM port, the program loader port and the status outputs.
interface mem_port_ctrl_if;
    import phaethon_mem_pkg::*;

    logic [WORD_W-1:0] ramAddress;
    logic [WORD_W-1:0] ramOut;
    logic              readReq;
    logic              writeReq;
    logic [WORD_W-1:0] ramIn;

    logic              ldValid;
    logic [WORD_W-1:0] ldAddr;
    logic [WORD_W-1:0] ldData;
    logic              ldDone;
    logic              ldReady;

    logic              cpuRun;
    logic [WORD_W-1:0] ledReg;
    logic [7:0]        errCount;

    modport master (
        output ramAddress, ramOut, readReq, writeReq,
        output ldValid, ldAddr, ldData, ldDone,
        input  ramIn, ldReady, cpuRun, ledReg, errCount
    );

    modport slave (
        input  ramAddress, ramOut, readReq, writeReq,
        input  ldValid, ldAddr, ldData, ldDone,
        output ramIn, ldReady, cpuRun, ledReg, errCount
    );

endinterface

// File: rtl/mem_port_ctrl_ram.sv
// Single-port synchronous word RAM with a registered read port.
// The read register can be loaded from a bypass value so non-RAM reads share the same output timing.
module mem_word_ram
    import phaethon_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              byp_en,
    input  logic [WORD_W-1:0] byp_data,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];
    logic [WORD_W-1:0] r_rdata;

    // Storage array; contents are initialised by the clear phase rather than by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register: write-through on a simultaneous write, holds when no read is active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= {WORD_W{1'b0}};
        end else if (re) begin
            if (byp_en) begin
                r_rdata <= byp_data;
            end else if (we) begin
                r_rdata <= wdata;
            end else begin
                r_rdata <= mem[addr];
            end
        end else begin
            r_rdata <= r_rdata;
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/mem_port_ctrl.sv
// Memory-side stage for the Phaethon core: clears RAM, accepts a program image,
// then releases the core and serves its level-sensitive reads/writes plus one MMIO register.
module mem_port_ctrl
    import phaethon_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] MMIO_ADDR   = MMIO_ADDR_DEF
) (
    input  logic            clk,
    input  logic            reset,
    mem_port_ctrl_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    mem_state_t        r_state;
    mem_state_t        w_state_nxt;
    logic [AW-1:0]     r_clr_cnt;
    logic              r_cpu_run;
    logic [WORD_W-1:0] r_led;
    logic [7:0]        r_err;

    logic              w_clr_last;
    logic              w_ld_in_range;
    logic              w_core_in_range;
    logic              w_core_mmio;
    logic              w_core_req;
    logic              w_err_inc;
    logic              w_led_we;

    logic              w_we;
    logic              w_re;
    logic [AW-1:0]     w_addr;
    logic [WORD_W-1:0] w_wdata;
    logic              w_byp_en;
    logic [WORD_W-1:0] w_byp_data;
    logic [WORD_W-1:0] w_rdata;

    assign w_clr_last      = (r_clr_cnt == AW'(DEPTH_WORDS - 1));
    assign w_ld_in_range   = (bus.ldAddr < 32'(DEPTH_WORDS));
    assign w_core_in_range = (bus.ramAddress < 32'(DEPTH_WORDS));
    assign w_core_mmio     = (bus.ramAddress == MMIO_ADDR);
    assign w_core_req      = bus.readReq | bus.writeReq;

    // Bad accesses: loader outside RAM (including the MMIO word), or core outside RAM and MMIO.
    assign w_err_inc = ((r_state == S_LOAD) && bus.ldValid && !w_ld_in_range) ||
                       ((r_state == S_RUN) && w_core_req && !w_core_in_range && !w_core_mmio);
    assign w_led_we  = (r_state == S_RUN) && bus.writeReq && !w_core_in_range && w_core_mmio;

    // Phase register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Phase sequencing: clear runs exactly DEPTH_WORDS cycles, load ends on ldDone, run is terminal.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: begin
                if (w_clr_last) begin
                    w_state_nxt = S_LOAD;
                end else begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_LOAD: begin
                if (bus.ldDone) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_RUN: begin
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_CLEAR;
            end
        endcase
    end

    // Clear address counter; parked at zero outside the clear phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clr_cnt <= {AW{1'b0}};
        end else if (r_state == S_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + AW'(1);
        end else begin
            r_clr_cnt <= {AW{1'b0}};
        end
    end

    // RAM port owner per phase; non-RAM core reads load the read register through the bypass.
    always_comb begin
        w_we       = 1'b0;
        w_re       = 1'b0;
        w_addr     = {AW{1'b0}};
        w_wdata    = {WORD_W{1'b0}};
        w_byp_en   = 1'b0;
        w_byp_data = {WORD_W{1'b0}};
        case (r_state)
            S_CLEAR: begin
                w_we   = 1'b1;
                w_addr = r_clr_cnt;
            end
            S_LOAD: begin
                w_we    = bus.ldValid && w_ld_in_range;
                w_addr  = bus.ldAddr[AW-1:0];
                w_wdata = bus.ldData;
            end
            S_RUN: begin
                w_we    = bus.writeReq && w_core_in_range;
                w_re    = bus.readReq;
                w_addr  = bus.ramAddress[AW-1:0];
                w_wdata = bus.ramOut;
                if (w_core_in_range) begin
                    w_byp_en = 1'b0;
                end else begin
                    w_byp_en = 1'b1;
                    if (w_core_mmio) begin
                        if (bus.writeReq) begin
                            w_byp_data = bus.ramOut;
                        end else begin
                            w_byp_data = r_led;
                        end
                    end else begin
                        w_byp_data = {WORD_W{1'b0}};
                    end
                end
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
    end

    // Core release trails entry to the run phase by one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cpu_run <= 1'b0;
        end else begin
            r_cpu_run <= (r_state == S_RUN);
        end
    end

    // MMIO output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_led <= {WORD_W{1'b0}};
        end else if (w_led_we) begin
            r_led <= bus.ramOut;
        end else begin
            r_led <= r_led;
        end
    end

    // Out-of-range access counter, one count per offending request cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 8'd0;
        end else if (w_err_inc) begin
            r_err <= sat_inc8(r_err);
        end else begin
            r_err <= r_err;
        end
    end

    mem_word_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk      (clk),
        .rst_n    (reset),
        .we       (w_we),
        .re       (w_re),
        .addr     (w_addr),
        .wdata    (w_wdata),
        .byp_en   (w_byp_en),
        .byp_data (w_byp_data),
        .rdata    (w_rdata)
    );

    assign bus.ramIn    = w_rdata;
    assign bus.ldReady  = (r_state == S_LOAD) && bus.ldValid;
    assign bus.cpuRun   = r_cpu_run;
    assign bus.ledReg   = r_led;
    assign bus.errCount = r_err;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Randomised self-checking bench for mem_port_ctrl against a phase/array model of its behaviour.
module tb_mem_port_ctrl;
    localparam int          DEPTH = 16;
    localparam logic [31:0] MMIO  = 32'hFFFF_FF00;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_port_ctrl_if bus();

    mem_port_ctrl #(.DEPTH_WORDS(DEPTH), .MMIO_ADDR(MMIO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model: clear progress, loaded/running flags, memory image, MMIO value, error count.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_led;
    logic [31:0] m_ram_in;
    logic [7:0]  m_err;
    int          m_clr;
    bit          m_running;
    bit          m_cpu;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
        m_led = 32'd0; m_ram_in = 32'd0; m_err = 8'd0;
        m_clr = 0; m_running = 1'b0; m_cpu = 1'b0;
    endtask

    task automatic bump_err();
        if (m_err != 8'd255) m_err = m_err + 8'd1;
    endtask

    task automatic model_step();
        logic [31:0] a;
        if (reset !== 1'b1) return;
        m_cpu = m_running;
        if (m_clr < DEPTH) begin
            m_clr++;
        end else if (!m_running) begin
            if (bus.ldValid) begin
                if (bus.ldAddr < 32'(DEPTH)) m_mem[int'(bus.ldAddr)] = bus.ldData;
                else bump_err();
            end
            if (bus.ldDone) m_running = 1'b1;
        end else if (bus.readReq || bus.writeReq) begin
            a = bus.ramAddress;
            if (a < 32'(DEPTH)) begin
                if (bus.writeReq) m_mem[int'(a)] = bus.ramOut;
                if (bus.readReq)  m_ram_in = m_mem[int'(a)];
            end else if (a == MMIO) begin
                if (bus.writeReq) m_led = bus.ramOut;
                if (bus.readReq)  m_ram_in = m_led;
            end else begin
                bump_err();
                if (bus.readReq) m_ram_in = 32'd0;
            end
        end
    endtask

    task automatic compare_all();
        logic exp_rdy;
        exp_rdy = (m_clr == DEPTH) && !m_running && (bus.ldValid === 1'b1);
        chk("ramIn",    bus.ramIn, m_ram_in);
        chk("ldReady",  {31'd0, bus.ldReady}, {31'd0, exp_rdy});
        chk("cpuRun",   {31'd0, bus.cpuRun}, {31'd0, m_cpu});
        chk("ledReg",   bus.ledReg, m_led);
        chk("errCount", {24'd0, bus.errCount}, {24'd0, m_err});
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge, inputs change 1ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        #1;
    endtask

    task automatic idle_inputs();
        bus.ramAddress = 32'd0; bus.ramOut = 32'd0; bus.readReq = 1'b0; bus.writeReq = 1'b0;
        bus.ldValid = 1'b0; bus.ldAddr = 32'd0; bus.ldData = 32'd0; bus.ldDone = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ramIn"},    bus.ramIn, 32'd0);
        chk({tag, "_ldReady"},  {31'd0, bus.ldReady}, 32'd0);
        chk({tag, "_cpuRun"},   {31'd0, bus.cpuRun}, 32'd0);
        chk({tag, "_ledReg"},   bus.ledReg, 32'd0);
        chk({tag, "_errCount"}, {24'd0, bus.errCount}, 32'd0);
    endtask

    task automatic count_clear(input string tag);
        int cyc;
        cyc = 0;
        bus.ldValid = 1'b1; bus.ldAddr = 32'd5; bus.ldData = 32'd0;
        for (int i = 1; i <= 40 && cyc == 0; i++) begin
            tick();
            if (bus.ldReady === 1'b1) cyc = i;
        end
        chk(tag, 32'(cyc), 32'd16);
    endtask

    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_reset_outputs(tag);
        idle_inputs();
    endtask

    initial begin
        logic [31:0] rnd;
        idle_inputs();
        model_reset();
        repeat (3) tick();
        check_reset_outputs("por");
        reset = 1'b1;

        count_clear("clear_cycles");

        bus.ldAddr = 32'd0; bus.ldData = 32'h11;
        chk("ldReady_mirror_hi", {31'd0, bus.ldReady}, 32'd1);
        tick();
        bus.ldAddr = 32'd1; bus.ldData = 32'h22;
        tick();
        bus.ldValid = 1'b0;
        #1;
        chk("ldReady_mirror_lo", {31'd0, bus.ldReady}, 32'd0);

        for (int i = 0; i < 30; i++) begin
            bus.ldValid = 1'($urandom_range(0, 1));
            rnd = $urandom;
            bus.ldAddr = ($urandom_range(0, 3) == 0) ? (32'h0000_0100 | rnd) : 32'($urandom_range(4, DEPTH - 1));
            bus.ldData = $urandom;
            bus.readReq = 1'($urandom_range(0, 1));
            bus.ramAddress = 32'd1;
            tick();
        end
        bus.readReq = 1'b0;

        bus.ldValid = 1'b1; bus.ldAddr = 32'd2; bus.ldData = 32'h33; bus.ldDone = 1'b1;
        tick();
        bus.ldValid = 1'b0; bus.ldDone = 1'b0;
        chk("cpuRun_not_yet", {31'd0, bus.cpuRun}, 32'd0);
        tick();
        chk("cpuRun_rise", {31'd0, bus.cpuRun}, 32'd1);

        bus.readReq = 1'b1; bus.ramAddress = 32'd1;
        tick(); chk("rd_w1", bus.ramIn, 32'h22);
        bus.ramAddress = 32'd0;
        tick(); chk("rd_w0", bus.ramIn, 32'h11);
        bus.ramAddress = 32'd1;
        tick(); chk("rd_w1_again", bus.ramIn, 32'h22);
        bus.ramAddress = 32'd2;
        tick(); chk("rd_w2_done_word", bus.ramIn, 32'h33);
        bus.ramAddress = 32'd3;
        tick(); chk("rd_w3_cleared", bus.ramIn, 32'h0);

        bus.readReq = 1'b0; bus.writeReq = 1'b1; bus.ramAddress = MMIO; bus.ramOut = 32'hA5;
        tick(); chk("led_write", bus.ledReg, 32'hA5);
        bus.writeReq = 1'b0; bus.readReq = 1'b1;
        tick(); chk("led_read", bus.ramIn, 32'hA5);

        bus.writeReq = 1'b1; bus.readReq = 1'b1; bus.ramAddress = 32'd3; bus.ramOut = 32'h77;
        tick(); chk("wr_through", bus.ramIn, 32'h77);
        bus.writeReq = 1'b0; bus.readReq = 1'b0; bus.ramOut = 32'd0;
        tick(); chk("hold_idle", bus.ramIn, 32'h77);
        bus.ramAddress = 32'd0; bus.readReq = 1'b1;
        tick();
        bus.ramAddress = 32'd3;
        tick(); chk("rd_w3_later", bus.ramIn, 32'h77);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                7:       bus.ramAddress = MMIO;
                8, 9:    bus.ramAddress = 32'h0001_0000 + 32'($urandom_range(0, 1000));
                default: bus.ramAddress = 32'($urandom_range(0, DEPTH - 1));
            endcase
            bus.readReq  = 1'($urandom_range(0, 1));
            bus.writeReq = ($urandom_range(0, 2) == 0);
            bus.ramOut   = $urandom;
            bus.ldValid  = 1'($urandom_range(0, 1));
            bus.ldAddr   = 32'($urandom_range(0, DEPTH + 4));
            bus.ldData   = $urandom;
            bus.ldDone   = 1'($urandom_range(0, 1));
            tick();
        end

        idle_inputs();
        bus.readReq = 1'b1; bus.ramAddress = 32'h0000_1000;
        repeat (300) tick();
        chk("err_saturate", {24'd0, bus.errCount}, 32'd255);
        chk("oor_read_zero", bus.ramIn, 32'd0);

        async_reset("rst_run");
        repeat (2) tick();
        reset = 1'b1;

        repeat (5) tick();
        async_reset("rst_clear");
        tick();
        reset = 1'b1;
        count_clear("clear_restart");

        bus.ldAddr = 32'h0000_0040; bus.ldValid = 1'b1;
        tick();
        chk("ld_oor_count", {24'd0, bus.errCount}, 32'd1);
        async_reset("rst_load");
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
